// File: rtl/fwd_pkg.sv
// fwd_pkg: shared FSM state, select and port-index constants for the forwarding/hazard unit
package fwd_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MD_WAIT = 2'd2} fwd_state_t;
  localparam int FWD_RF = 0;
  localparam int P_RS1  = 0;
  localparam int P_RS2  = 1;
  localparam int P_DATA = 2;
  localparam int P_CMP  = 3;
endpackage

// File: rtl/fwd_port_match.sv
// fwd_port_match: combinational youngest-first forwarding match for one source port
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int R      = 5,
  parameter int NSTAGE = 2,
  parameter int SELW   = $clog2(NSTAGE + 1)
) (
  input  logic [R-1:0]        addr,
  input  logic                en,
  input  logic [NSTAGE*R-1:0] rd,
  input  logic [NSTAGE-1:0]   we,
  output logic [SELW-1:0]     sel
);
  // scan oldest to youngest so the youngest hit overwrites
  always_comb begin
    sel = SELW'(FWD_RF);
    for (int s = NSTAGE - 1; s >= 0; s--)
      sel = (en && we[s] && rd[s*R +: R] != '0 && rd[s*R +: R] == addr) ? SELW'(s + 1) : sel;
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: registered per-port forward selects plus load-use / mul-div stall sequencing
// Optional perf counters enabled by defining FWD_HAZARD_PERF_EN.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int R      = 5,
  parameter int NPORT  = 4,
  parameter int NSTAGE = 2,
  parameter int SELW   = $clog2(NSTAGE + 1)
) (
  input  logic                  clk,
  input  logic                  a_reset_n,
  input  logic                  dec_valid,
  input  logic [NPORT*R-1:0]    dec_addr,
  input  logic [NPORT-1:0]      dec_use,
  input  logic [NSTAGE*R-1:0]   stage_rd,
  input  logic [NSTAGE-1:0]     stage_we,
  input  logic                  ex_is_load,
  input  logic                  md_busy,
  output logic [NPORT*SELW-1:0] fwd_sel,
  output logic                  stall,
  output logic                  ex_bubble
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_lu_cnt
`endif
);
  fwd_state_t state;
  logic [NPORT*SELW-1:0] sel_c;
  logic [NPORT-1:0] hit0;
  logic lu_c;
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    fwd_port_match #(.R(R), .NSTAGE(NSTAGE), .SELW(SELW)) u_match (
      .addr(dec_addr[p*R +: R]),
      .en  (dec_use[p]),
      .rd  (stage_rd),
      .we  (stage_we),
      .sel (sel_c[p*SELW +: SELW])
    );
    assign hit0[p] = sel_c[p*SELW +: SELW] == SELW'(1);
  end
  assign lu_c  = dec_valid & ex_is_load & |hit0;
  // a load-use hit is only honoured from RUN; in LU_STALL the EX stage view is stale
  assign stall = a_reset_n & (md_busy | (state == RUN & lu_c));
  always_ff @(posedge clk) begin
    if (!a_reset_n) begin
      state     <= RUN;
      fwd_sel   <= '0;
      ex_bubble <= 1'b0;
    end else begin
      state     <= md_busy ? MD_WAIT : (state == RUN && lu_c) ? LU_STALL : RUN;
      fwd_sel   <= stall ? '0 : sel_c;
      ex_bubble <= stall;
    end
  end
`ifdef FWD_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!a_reset_n) begin
      perf_stall_cnt <= '0;
      perf_lu_cnt    <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + 32'(stall);
      perf_lu_cnt    <= perf_lu_cnt + 32'(state == RUN && !md_busy && lu_c);
    end
  end
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed + random scoreboard bench against a behavioural hazard model
module tb_fwd_hazard_unit;
  localparam int R = 5, NPORT = 4, NSTAGE = 2, SELW = 2;
  logic clk = 0;
  logic a_reset_n, dec_valid, ex_is_load, md_busy, stall, ex_bubble;
  logic [NPORT*R-1:0] dec_addr;
  logic [NPORT-1:0] dec_use;
  logic [NSTAGE*R-1:0] stage_rd;
  logic [NSTAGE-1:0] stage_we;
  logic [NPORT*SELW-1:0] fwd_sel;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_lu_cnt;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fwd_hazard_unit #(.R(R), .NPORT(NPORT), .NSTAGE(NSTAGE), .SELW(SELW)) dut (
    .clk(clk), .a_reset_n(a_reset_n), .dec_valid(dec_valid), .dec_addr(dec_addr),
    .dec_use(dec_use), .stage_rd(stage_rd), .stage_we(stage_we), .ex_is_load(ex_is_load),
    .md_busy(md_busy), .fwd_sel(fwd_sel), .stall(stall), .ex_bubble(ex_bubble)
`ifdef FWD_HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_lu_cnt(perf_lu_cnt)
`endif
  );
  typedef struct {
    logic stall;
    logic [NPORT*SELW-1:0] sel;
    logic bub;
    logic known;
    logic [31:0] psc;
    logic [31:0] plc;
  } exp_t;
  exp_t q[$];
  // model state: registered outputs as of the last edge, plus "which wait are we in"
  logic [NPORT*SELW-1:0] m_sel;
  logic m_bub, m_known = 0, m_lu = 0, m_md = 0;
  logic [31:0] m_psc = 0, m_plc = 0;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("stall", 32'(stall), 32'(e.stall));
      if (e.known) begin
        for (int p = 0; p < NPORT; p++)
          check($sformatf("fwd_sel[%0d]", p), 32'(fwd_sel[p*SELW +: SELW]), 32'(e.sel[p*SELW +: SELW]));
        check("ex_bubble", 32'(ex_bubble), 32'(e.bub));
`ifdef FWD_HAZARD_PERF_EN
        check("perf_stall_cnt", perf_stall_cnt, e.psc);
        check("perf_lu_cnt", perf_lu_cnt, e.plc);
`endif
      end
    end
  end
  task automatic step(input logic rn, input logic dv, input logic [NPORT*R-1:0] a,
                      input logic [NPORT-1:0] u, input logic [NSTAGE*R-1:0] rd,
                      input logic [NSTAGE-1:0] we, input logic ld, input logic md);
    logic [NPORT*SELW-1:0] sel_n;
    logic lu, fresh_lu, exp_stall;
    @(posedge clk);
    #1;
    a_reset_n = rn; dec_valid = dv; dec_addr = a; dec_use = u;
    stage_rd = rd; stage_we = we; ex_is_load = ld; md_busy = md;
    lu = 0;
    for (int p = 0; p < NPORT; p++) begin
      int pick = 0;
      for (int s = 0; s < NSTAGE; s++)
        if (pick == 0 && u[p] && we[s] && rd[s*R +: R] != 0 && rd[s*R +: R] == a[p*R +: R]) pick = s + 1;
      sel_n[p*SELW +: SELW] = SELW'(pick);
      if (pick == 1 && dv && ld) lu = 1;
    end
    fresh_lu = lu && !m_lu && !m_md;
    exp_stall = rn && (md || fresh_lu);
    q.push_back('{exp_stall, m_sel, m_bub, m_known, m_psc, m_plc});
    if (!rn) begin
      m_sel = '0; m_bub = 0; m_lu = 0; m_md = 0; m_psc = 0; m_plc = 0; m_known = 1;
    end else begin
      m_sel = exp_stall ? '0 : sel_n;
      m_bub = exp_stall;
      m_lu  = fresh_lu && !md;
      m_plc = m_plc + 32'(fresh_lu && !md);
      m_psc = m_psc + 32'(exp_stall);
      m_md  = md;
    end
  endtask
  function automatic logic [NPORT*R-1:0] ports(input int a0, a1, a2, a3);
    return {R'(a3), R'(a2), R'(a1), R'(a0)};
  endfunction
  function automatic logic [NSTAGE*R-1:0] stages(input int r0, r1);
    return {R'(r1), R'(r0)};
  endfunction
  initial begin
    step(0, 0, '0, '0, '0, '0, 0, 0);
    step(0, 0, '0, '0, '0, '0, 0, 0);
    // RAW on EX
    step(1, 1, ports(5, 0, 0, 0), 4'b0001, stages(5, 0), 2'b01, 0, 0);
    step(1, 1, '0, '0, '0, '0, 0, 0);
    // priority and x0
    step(1, 1, ports(0, 7, 0, 0), 4'b0010, stages(7, 7), 2'b11, 0, 0);
    step(1, 1, ports(0, 0, 0, 0), 4'b0010, stages(0, 7), 2'b11, 0, 0);
    step(1, 1, '0, '0, '0, '0, 0, 0);
    // load-use, then the load moves to MEM
    step(1, 1, ports(9, 0, 0, 0), 4'b0001, stages(9, 0), 2'b01, 1, 0);
    step(1, 1, ports(9, 0, 0, 0), 4'b0001, stages(0, 9), 2'b10, 0, 0);
    step(1, 1, '0, '0, '0, '0, 0, 0);
    // mul/div with concurrent load-use, back to RUN with no fresh hit
    step(1, 0, '0, '0, '0, '0, 0, 0);
    step(0, 0, '0, '0, '0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, ports(9, 0, 0, 0), 4'b0001, stages(9, 0), 2'b01, 1, 1);
    step(1, 1, ports(9, 0, 0, 0), 4'b0001, stages(0, 9), 2'b10, 0, 0);
    step(1, 1, '0, '0, '0, '0, 0, 0);
    // reset mid-stall
    step(1, 1, '0, '0, '0, '0, 0, 1);
    step(1, 1, '0, '0, '0, '0, 0, 1);
    step(0, 1, ports(3, 0, 0, 0), 4'b0001, stages(3, 0), 2'b01, 1, 1);
    step(1, 1, '0, '0, '0, '0, 0, 0);
    // write-enable gating on the store-data port
    step(1, 1, ports(0, 0, 12, 0), 4'b0100, stages(0, 12), 2'b00, 0, 0);
    step(1, 1, '0, '0, '0, '0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [NPORT*R-1:0] a;
      logic [NSTAGE*R-1:0] rd;
      for (int p = 0; p < NPORT; p++) a[p*R +: R] = R'($urandom_range(0, 3));
      for (int s = 0; s < NSTAGE; s++) rd[s*R +: R] = R'($urandom_range(0, 3));
      step($urandom_range(0, 99) > 2, $urandom_range(0, 9) > 1, a, NPORT'($urandom), rd,
           NSTAGE'($urandom), $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
